ahb_lite_sram_slave: RTL and testbench
======================================

# ahb_lite_sram_slave

AHB-Lite slave responder with a byte-addressable SRAM behind it. It answers transfers driven by the AHB master BFM through `AHBInterface`, and is instantiated next to that interface in the emulation HDL top. It supports programmable wait states, byte/halfword/word accesses, and the two-cycle ERROR response for illegal accesses. It is synthesizable for the emulator (XRTL-compatible, no delays).

## Interface
- `ADDR_WIDTH`, 32: HADDR width.
- `DATA_WIDTH`, 32: HWDATA/HRDATA width. Only 32 is supported.
- `MEM_DEPTH`, 1024: number of 32-bit words. Valid byte range is 0 .. 4*MEM_DEPTH-1.
- `WAIT_STATES`, 0: HREADYOUT-low cycles inserted in each OKAY data phase (0..15).

Ports:
- `HCLK` in 1: clock. One clock domain.
- `HRESETn` in 1: reset. Synchronous, active-low.
- `HSEL` in 1: slave select.
- `HADDR` in ADDR_WIDTH: byte address.
- `HWRITE` in 1: 1 = write.
- `HSIZE` in 3: 0 = byte, 1 = half, 2 = word.
- `HBURST` in 3: accepted and ignored. Each beat is handled as a single transfer.
- `HTRANS` in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `HWDATA` in DATA_WIDTH: write data, valid in the data phase.
- `HREADY` in 1: bus-level ready; qualifies the address phase.
- `HRDATA` out DATA_WIDTH: read data.
- `HREADYOUT` out 1: slave ready.
- `HRESP` out 1: 0 = OKAY, 1 = ERROR.

## Operation
- **Address-phase capture.** An address phase is accepted on an HCLK edge when `HSEL && HREADY && HTRANS[1]`.
  - On acceptance, register addr, write, size, and an error flag.
  - IDLE/BUSY beats and unselected beats: the next data phase is zero-wait OKAY.
- **Error conditions.** Any of the following sets the error flag:
  - address ≥ 4*MEM_DEPTH;
  - HSIZE > 2;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0]≠0.
- **FSM states:**
  - `IDLE`: no data phase active. If a transfer is accepted with error → `ERR1`. If accepted with WAIT_STATES>0 → `WAIT`. If accepted with WAIT_STATES=0 → `DATA`.
  - `WAIT`: counter counts down from WAIT_STATES; HREADYOUT=0; at 0 → `DATA`.
  - `DATA`: HREADYOUT=1, HRESP=0. A write commits HWDATA lanes on this edge. A read drives HRDATA. A new accepted transfer on the same edge re-enters `WAIT`/`DATA`/`ERR1`; otherwise → `IDLE`.
  - `ERR1`: HREADYOUT=0, HRESP=1; → `ERR2`. Nothing is written.
  - `ERR2`: HREADYOUT=1, HRESP=1. A new accepted transfer is handled as from `DATA`; otherwise → `IDLE`.
- **Byte lanes.** Lanes are little-endian.
  - Byte: lane HADDR[1:0].
  - Half: lanes {HADDR[1],0} and {HADDR[1],1}.
  - Word: all four lanes.
  - Reads return the full word; unused lanes carry memory contents.
- **Read-after-write.** The array read is combinational from the registered address, so a read whose data phase immediately follows a write to the same word returns the new data.
- **Reset.** HRESETn low on an edge:
  - state → `IDLE`, HREADYOUT=1, HRESP=0, HRDATA=0;
  - any pending transfer is dropped;
  - memory contents are preserved.

## Timing
- Read latency: data is valid on the edge that ends the data phase, i.e. WAIT_STATES+1 cycles after the address-phase edge.
- Writes commit on the same edge.
- Back-to-back NONSEQ/SEQ with WAIT_STATES=0 sustains one beat per cycle.
- HRDATA holds its last value outside read data phases. It changes only in `DATA` for reads.
- ERROR response is always exactly 2 cycles, regardless of WAIT_STATES.
- HREADY low from another slave: no capture occurs; the FSM is unaffected while in `IDLE`.

## Structure
- `ahb_pkg` holds:
  - the `htrans_e` and `hsize_e` enums;
  - HRESP_OKAY/HRESP_ERROR constants;
  - the `slv_state_e` FSM enum;
  - the function `ahb_lane_mask(size, addr[1:0])` returning a 4-bit byte enable.
- Sub-module `ahb_sram_array`: 1 write port with byte enables, 1 combinational read port, MEM_DEPTH×32. All protocol logic stays in the top module.

## Test plan
- **Reset:** hold HRESETn=0 for 2 cycles → HREADYOUT=1, HRESP=0, HRDATA=0.
- **Word write/read:** WAIT_STATES=0; write 0xDEADBEEF @0x10, then read @0x10 back-to-back → HRDATA=0xDEADBEEF in the cycle after the read address phase.
- **Sub-word writes:** byte write 0xAA @0x13, then halfword write 0x1234 @0x10, over the word 0xDEADBEEF → read @0x10 returns 0xAAAD1234.
- **Wait states:** WAIT_STATES=3, read → HREADYOUT low for exactly 3 cycles, then high with data.
- **Errors:**
  - address 0x1000 with MEM_DEPTH=1024 → HRESP=1 with HREADYOUT 0 then 1.
  - misaligned word @0x2 → same response, memory unchanged.
- **Reset mid-transfer:** assert HRESETn=0 during the `WAIT` of a write → write dropped, old data read back after reset.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane helper
// used by the SRAM slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } slv_state_e;

  // Little-endian byte enables; unsupported sizes enable no lanes.
  function automatic logic [3:0] ahb_lane_mask(input logic [2:0] size,
                                               input logic [1:0] addr);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr;
      HSIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: mask = 4'b1111;
      default:    mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// MEM_DEPTH x 32 storage: one byte-enabled synchronous write port and one
// combinational read port. Contents are never reset.
module ahb_sram_array #(
  parameter int MEM_DEPTH = 1024,
  localparam int IDX_W = $clog2(MEM_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [3:0]       i_be,
  input  logic [IDX_W-1:0] i_wIdx,
  input  logic [31:0]      i_wData,
  input  logic [IDX_W-1:0] i_rIdx,
  output logic [31:0]      o_rData
);

  logic [31:0] r_mem [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_wIdx][8*i +: 8] <= i_wData[8*i +: 8];
      end
    end
  end

  assign o_rData = r_mem[i_rIdx];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave in front of a byte-addressable SRAM, with programmable
// OKAY wait states and the two-cycle ERROR response for illegal accesses.
module ahb_lite_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

  slv_state_e       r_state, w_nextState;
  logic [3:0]       r_waitCnt, w_nextWaitCnt;
  logic [IDX_W-1:0] r_wordIdx;
  logic [1:0]       r_byteOff;
  logic [2:0]       r_size;
  logic             r_write;
  logic             r_err;
  logic [DATA_WIDTH-1:0] r_rdHold;

  logic        w_accept;
  logic        w_addrPhaseOpen;
  logic        w_err;
  logic        w_we;
  logic        w_rdActive;
  logic [31:0] w_rData;
  logic        w_unused;

  assign w_unused = ^{HBURST, HTRANS[0]};

  assign w_addrPhaseOpen = (r_state == S_IDLE) || (r_state == S_DATA) ||
                           (r_state == S_ERR2);
  assign w_accept = HSEL && HREADY && HTRANS[1];

  assign w_err = ({1'b0, HADDR} >= BYTE_LIMIT) ||
                 (HSIZE > 3'd2) ||
                 ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                 ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state   <= S_IDLE;
      r_waitCnt <= '0;
      r_wordIdx <= '0;
      r_byteOff <= '0;
      r_size    <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_rdHold  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
      if (w_accept && w_addrPhaseOpen) begin
        r_wordIdx <= HADDR[IDX_W+1:2];
        r_byteOff <= HADDR[1:0];
        r_size    <= HSIZE;
        r_write   <= HWRITE;
        r_err     <= w_err;
      end
      if (w_rdActive) r_rdHold <= w_rData;
    end
  end

  // IDLE, DATA and ERR2 all close a beat, so each may start the next one.
  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    case (r_state)
      S_IDLE, S_DATA, S_ERR2: begin
        w_nextState = S_IDLE;
        if (w_accept) begin
          if (w_err) begin
            w_nextState = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_nextState   = S_WAIT;
            w_nextWaitCnt = 4'(WAIT_STATES - 1);
          end else begin
            w_nextState = S_DATA;
          end
        end
      end
      S_WAIT: begin
        if (r_waitCnt == 4'd0) w_nextState = S_DATA;
        else w_nextWaitCnt = r_waitCnt - 4'd1;
      end
      S_ERR1:  w_nextState = S_ERR2;
      default: w_nextState = S_IDLE;
    endcase
  end

  assign w_we       = (r_state == S_DATA) && r_write && !r_err;
  assign w_rdActive = (r_state == S_DATA) && !r_write;

  assign HREADYOUT = !((r_state == S_WAIT) || (r_state == S_ERR1));
  assign HRESP     = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? HRESP_ERROR
                                                                    : HRESP_OKAY;
  assign HRDATA    = w_rdActive ? w_rData : r_rdHold;

  ahb_sram_array #(
    .MEM_DEPTH(MEM_DEPTH)
  ) u_array (
    .i_clk   (HCLK),
    .i_we    (w_we),
    .i_be    (ahb_lane_mask(r_size, r_byteOff)),
    .i_wIdx  (r_wordIdx),
    .i_wData (HWDATA),
    .i_rIdx  (r_wordIdx),
    .o_rData (w_rData)
  );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Scoreboard bench: two slaves (0 and 3 wait states) driven by a pipelined
// AHB master model, checked against a byte-array reference memory.
module tb_ahb_lite_sram_slave;

  typedef struct {
    bit          isRead;
    logic [31:0] rdata;
    bit          resp;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn      [2];
  logic        hsel      [2];
  logic        hwrite    [2];
  logic        hready    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic        forceLow  [2];
  logic [31:0] haddr     [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic [2:0]  hsize     [2];
  logic [2:0]  hburst    [2];
  logic [1:0]  htrans    [2];

  logic [31:0]  prevWdata [2];
  byte unsigned mdl [2][4096];
  exp_t         q0[$];
  exp_t         q1[$];
  int           cmpCount = 0;
  int           errCount = 0;

  always #5 clk = ~clk;

  // Bus-level HREADY is the slave's own HREADYOUT unless another slave holds it low.
  assign hready[0] = hreadyout[0] & ~forceLow[0];
  assign hready[1] = hreadyout[1] & ~forceLow[1];

  ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rstn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HSIZE(hsize[0]), .HBURST(hburst[0]), .HTRANS(htrans[0]), .HWDATA(hwdata[0]),
    .HREADY(hready[0]), .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]));

  ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESETn(rstn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HSIZE(hsize[1]), .HBURST(hburst[1]), .HTRANS(htrans[1]), .HWDATA(hwdata[1]),
    .HREADY(hready[1]), .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]));

  function automatic int wsOf(input int b);
    return (b == 0) ? 0 : 3;
  endfunction

  task automatic checkOutput(input string name, input int b,
                             input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s bus%0d: got 0x%08h expected 0x%08h at %0t", name, b, act, exp, $time);
    end
  endtask

  // Reference behaviour of one accepted beat: legality, lane update, read word.
  task automatic modelBeat(input int b, input bit wr, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    bit   err;
    int   base, lo, hi;
    err = (addr >= 32'd4096) || (size > 3'd2) ||
          ((size == 3'd1) && addr[0]) || ((size == 3'd2) && (addr[1:0] != 2'b00));
    e.isRead = !wr;
    e.resp   = err;
    e.waits  = err ? 1 : wsOf(b);
    e.rdata  = '0;
    if (!err) begin
      base = int'(addr) & ~3;
      if (wr) begin
        lo = (size == 3'd0) ? int'(addr[1:0]) : (size == 3'd1) ? int'(addr[1:0]) & 2 : 0;
        hi = (size == 3'd0) ? lo : (size == 3'd1) ? lo + 1 : 3;
        for (int l = lo; l <= hi; l++) mdl[b][base + l] = wdata[8*l +: 8];
      end else begin
        e.rdata = {mdl[b][base+3], mdl[b][base+2], mdl[b][base+1], mdl[b][base]};
      end
    end
    if (b == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // One address phase; returns just after the edge that accepted it.
  task automatic applyStimulus(input int b, input bit sel, input logic [1:0] trans,
                               input bit wr, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input bit track);
    int n;
    hsel[b]   = sel;
    htrans[b] = trans;
    hwrite[b] = wr;
    hsize[b]  = size;
    haddr[b]  = addr;
    hburst[b] = 3'($urandom_range(0, 7));
    hwdata[b] = prevWdata[b];
    n = 0;
    @(negedge clk);
    while (!hready[b] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!hready[b]) checkOutput("handshakeTimeout", b, {31'd0, hready[b]}, 32'd1);
    @(posedge clk);
    #1;
    prevWdata[b] = (sel && trans[1] && wr) ? wdata : $urandom;
    if (track && sel && trans[1]) modelBeat(b, wr, size, addr, wdata);
  endtask

  task automatic idleBeat(input int b);
    applyStimulus(b, 1'b0, 2'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic monitorBus(input int b);
    bit   active = 0;
    int   waits = 0;
    int   respW = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn[b]) begin
        active = 0;
        waits  = 0;
        respW  = 0;
        continue;
      end
      if (active) begin
        if (!hreadyout[b]) begin
          waits++;
          if (hresp[b]) respW++;
        end else begin
          if ((b == 0 && q0.size() == 0) || (b == 1 && q1.size() == 0)) begin
            checkOutput("unexpectedBeat", b, 32'd1, 32'd0);
          end else begin
            e = (b == 0) ? q0.pop_front() : q1.pop_front();
            checkOutput("waitCycles", b, 32'(waits), 32'(e.waits));
            checkOutput("hresp", b, {31'd0, hresp[b]}, {31'd0, e.resp});
            checkOutput("waitResp", b, 32'(respW), e.resp ? 32'd1 : 32'd0);
            if (e.isRead && !e.resp) checkOutput("hrdata", b, hrdata[b], e.rdata);
          end
          active = 0;
          waits  = 0;
          respW  = 0;
        end
      end
      if (!active && hsel[b] && hready[b] && htrans[b][1]) active = 1;
    end
  endtask

  task automatic randomBeats(input int b, input int count);
    logic [2:0]  size;
    logic [31:0] addr;
    for (int i = 0; i < count; i++) begin
      size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      addr = $urandom_range(0, 255);
      if ($urandom_range(0, 4) != 0) begin
        if (size == 3'd1) addr[0] = 1'b0;
        if (size == 3'd2) addr[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) addr = 32'h1000 + 32'($urandom_range(0, 15));
      applyStimulus(b, $urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), size, addr, $urandom, 1'b1);
    end
  endtask

  task automatic runBus(input int b);
    for (int w = 0; w < 64; w++) applyStimulus(b, 1, 2'd2, 1, 3'd2, 32'(4*w), $urandom, 1);
    // Back-to-back word write then read of the same word.
    applyStimulus(b, 1, 2'd2, 1, 3'd2, 32'h10, 32'hDEADBEEF, 1);
    applyStimulus(b, 1, 2'd3, 0, 3'd2, 32'h10, 32'h0, 1);
    // Sub-word lanes over 0xDEADBEEF: read should give 0xAAAD1234.
    applyStimulus(b, 1, 2'd2, 1, 3'd0, 32'h13, 32'hAA000000, 1);
    applyStimulus(b, 1, 2'd2, 1, 3'd1, 32'h10, 32'h00001234, 1);
    applyStimulus(b, 1, 2'd2, 0, 3'd2, 32'h10, 32'h0, 1);
    // Out-of-range read, misaligned write, then confirm word 0 unchanged.
    applyStimulus(b, 1, 2'd2, 0, 3'd2, 32'h1000, 32'h0, 1);
    applyStimulus(b, 1, 2'd2, 1, 3'd2, 32'h2, 32'h55AA55AA, 1);
    applyStimulus(b, 1, 2'd2, 0, 3'd2, 32'h0, 32'h0, 1);
    applyStimulus(b, 1, 2'd2, 1, 3'd1, 32'h21, 32'h77777777, 1);
    idleBeat(b);
    if (b == 0) begin
      // Another slave holds HREADY low over a write address phase.
      hsel[b] = 1; htrans[b] = 2'd2; hwrite[b] = 1; hsize[b] = 3'd2;
      haddr[b] = 32'h24; hwdata[b] = 32'hBAD0BAD0; forceLow[b] = 1;
      repeat (3) @(posedge clk);
      #1;
      hsel[b] = 0; htrans[b] = 2'd0; forceLow[b] = 0;
      prevWdata[b] = 32'hBAD0BAD0;
      applyStimulus(b, 1, 2'd2, 0, 3'd2, 32'h24, 32'h0, 1);
    end else begin
      // Reset during the wait states of a write drops it.
      applyStimulus(b, 1, 2'd2, 1, 3'd2, 32'h20, 32'h12345678, 0);
      hsel[b] = 0; htrans[b] = 2'd0; hwdata[b] = 32'h12345678;
      @(posedge clk);
      #1;
      rstn[b] = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("midResetHreadyout", b, {31'd0, hreadyout[b]}, 32'd1);
      checkOutput("midResetHresp", b, {31'd0, hresp[b]}, 32'd0);
      checkOutput("midResetHrdata", b, hrdata[b], 32'd0);
      @(posedge clk);
      #1;
      rstn[b] = 1;
      applyStimulus(b, 1, 2'd2, 0, 3'd2, 32'h20, 32'h0, 1);
    end
    randomBeats(b, (b == 0) ? 400 : 150);
    idleBeat(b);
    idleBeat(b);
  endtask

  initial begin
    int n;
    for (int b = 0; b < 2; b++) begin
      rstn[b] = 0; hsel[b] = 0; hwrite[b] = 0; forceLow[b] = 0;
      haddr[b] = '0; hwdata[b] = '0; hsize[b] = '0; hburst[b] = '0;
      htrans[b] = '0; prevWdata[b] = '0;
    end
    fork
      monitorBus(0);
      monitorBus(1);
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      checkOutput("resetHreadyout", b, {31'd0, hreadyout[b]}, 32'd1);
      checkOutput("resetHresp", b, {31'd0, hresp[b]}, 32'd0);
      checkOutput("resetHrdata", b, hrdata[b], 32'd0);
    end
    @(posedge clk);
    #1;
    rstn[0] = 1;
    rstn[1] = 1;
    fork
      runBus(0);
      runBus(1);
    join
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0)
      checkOutput("drainQueues", 0, 32'(q0.size() + q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
